instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 203 ++++++++++++++++++++
 tb/tb_instr_fetch.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch and issue front end.  Reads a 16-bit instruction from
// memory at PC, latches it into IR, hands it to the controller with a
// one-cycle start pulse, then waits for the controller to finish before
// fetching the next word.  The controller may redirect the PC while it is
// executing.
//
// Ports
//   clk        in   1   sole clock, rising edge
//   reset      in   1   asynchronous reset, active low
//   mem_addr   out  9   instruction read address (always PC)
//   mem_rd     out  1   read request
//   mem_rdata  in   16  read data, valid with mem_ready
//   mem_ready  in   1   read complete
//   w          in   1   controller waiting for an instruction
//   pc_load    in   1   branch target write strobe (honoured in EXEC only)
//   pc_in      in   9   branch target
//   s          out  1   one-cycle start pulse to the controller
//   opcode     out  3   IR[15:13]
//   op         out  2   IR[12:11]
//   rn         out  3   IR[10:8]
//   rd         out  3   IR[7:5]
//   shift      out  2   IR[4:3]
//   rm         out  3   IR[2:0]
//   sximm8     out  16  IR[7:0] sign-extended
//   sximm5     out  16  IR[4:0] sign-extended
//   PC         out  9   program counter
//   halted     out  1   halt instruction reached
//   fault      out  1   memory read timed out
//
// Build option
//   FETCH_TIMEOUT_EN  when defined, a read outstanding for 15 WAITMEM cycles
//                     moves the block to FAULT.  When undefined the read waits
//                     forever and fault is tied low.
//
// States
//   state   | meaning
//   --------+---------------------------------------------------------------
//   FETCH   | launch a read at PC
//   WAITMEM | read outstanding, mem_rd held high
//   ISSUE   | IR valid, waiting for the controller to be ready
//   EXEC    | controller busy; wait for w to drop and then rise again
//   HALT    | halt opcode seen, frozen until reset
//   FAULT   | read timed out, frozen until reset
// -----------------------------------------------------------------------------
module instr_fetch (
   input  logic        clk,
   input  logic        reset,
   output logic [8:0]  mem_addr,
   output logic        mem_rd,
   input  logic [15:0] mem_rdata,
   input  logic        mem_ready,
   input  logic        w,
   input  logic        pc_load,
   input  logic [8:0]  pc_in,
   output logic        s,
   output logic [2:0]  opcode,
   output logic [1:0]  op,
   output logic [2:0]  rn,
   output logic [2:0]  rd,
   output logic [2:0]  rm,
   output logic [1:0]  shift,
   output logic [15:0] sximm8,
   output logic [15:0] sximm5,
   output logic [8:0]  PC,
   output logic        halted,
   output logic        fault
);

   typedef enum logic [2:0] {
      ST_FETCH   = 3'd0,
      ST_WAITMEM = 3'd1,
      ST_ISSUE   = 3'd2,
      ST_EXEC    = 3'd3,
      ST_HALT    = 3'd4,
      ST_FAULT   = 3'd5
   } state_t;

   localparam logic [2:0] OPC_HALT = 3'b111;

   state_t      state_q;
   logic [8:0]  pc_q;
   logic [15:0] ir_q;
   logic        s_q;
   logic        mem_rd_q;
   logic        halted_q;
   // Set once w has been seen low in EXEC; the next w high ends execution.
   logic        exec_w0_q;

`ifdef FETCH_TIMEOUT_EN
   // Down-counter loaded on entry to WAITMEM; terminal count 0 means the
   // 15th WAITMEM cycle has passed without mem_ready.
   localparam logic [3:0] TMO_LOAD = 4'd14;
   logic [3:0]  tmo_cnt_q;
   logic        fault_q;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_FETCH;
         pc_q      <= 9'd0;
         ir_q      <= 16'd0;
         s_q       <= 1'b0;
         mem_rd_q  <= 1'b0;
         halted_q  <= 1'b0;
         exec_w0_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
         tmo_cnt_q <= 4'd0;
         fault_q   <= 1'b0;
`endif
      end else begin
         // s is a pulse: only the ISSUE->EXEC transition raises it.
         s_q <= 1'b0;

         case (state_q)
            ST_FETCH: begin
               mem_rd_q <= 1'b1;
               state_q  <= ST_WAITMEM;
`ifdef FETCH_TIMEOUT_EN
               tmo_cnt_q <= TMO_LOAD;
`endif
            end

            ST_WAITMEM: begin
               if (mem_ready) begin
                  ir_q     <= mem_rdata;
                  pc_q     <= pc_q + 9'd1;
                  mem_rd_q <= 1'b0;
                  state_q  <= ST_ISSUE;
               end
`ifdef FETCH_TIMEOUT_EN
               else if (tmo_cnt_q == 4'd0) begin
                  mem_rd_q <= 1'b0;
                  fault_q  <= 1'b1;
                  state_q  <= ST_FAULT;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q - 4'd1;
               end
`endif
            end

            ST_ISSUE: begin
               // A halt opcode never reaches the controller.
               if (ir_q[15:13] == OPC_HALT) begin
                  halted_q <= 1'b1;
                  state_q  <= ST_HALT;
               end else if (w) begin
                  s_q       <= 1'b1;
                  exec_w0_q <= 1'b0;
                  state_q   <= ST_EXEC;
               end
            end

            ST_EXEC: begin
               if (pc_load) begin
                  pc_q <= pc_in;
               end
               if (!exec_w0_q) begin
                  if (!w) begin
                     exec_w0_q <= 1'b1;
                  end
               end else if (w) begin
                  state_q <= ST_FETCH;
               end
            end

            ST_HALT: begin
            end

            ST_FAULT: begin
            end

            default: begin
               state_q <= ST_FETCH;
            end
         endcase
      end
   end

   assign mem_addr = pc_q;
   assign mem_rd   = mem_rd_q;
   assign PC       = pc_q;
   assign s        = s_q;
   assign halted   = halted_q;

`ifdef FETCH_TIMEOUT_EN
   assign fault = fault_q;
`else
   assign fault = 1'b0;
`endif

   assign opcode = ir_q[15:13];
   assign op     = ir_q[12:11];
   assign rn     = ir_q[10:8];
   assign rd     = ir_q[7:5];
   assign shift  = ir_q[4:3];
   assign rm     = ir_q[2:0];
   assign sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};
   assign sximm5 = {{11{ir_q[4]}}, ir_q[4:0]};

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

`ifdef FETCH_TIMEOUT_EN
   localparam bit TMO = 1'b1;
`else
   localparam bit TMO = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic [8:0]  mem_addr;
   logic        mem_rd;
   logic [15:0] mem_rdata;
   logic        mem_ready;
   logic        w;
   logic        pc_load;
   logic [8:0]  pc_in;
   logic        s;
   logic [2:0]  opcode;
   logic [1:0]  op;
   logic [2:0]  rn;
   logic [2:0]  rd;
   logic [2:0]  rm;
   logic [1:0]  shift;
   logic [15:0] sximm8;
   logic [15:0] sximm5;
   logic [8:0]  PC;
   logic        halted;
   logic        fault;

   int n_checks = 0;
   int n_errors = 0;
   int s_cnt    = 0;
   int base;

   instr_fetch dut (
      .clk       (clk),
      .reset     (reset),
      .mem_addr  (mem_addr),
      .mem_rd    (mem_rd),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .w         (w),
      .pc_load   (pc_load),
      .pc_in     (pc_in),
      .s         (s),
      .opcode    (opcode),
      .op        (op),
      .rn        (rn),
      .rd        (rd),
      .rm        (rm),
      .shift     (shift),
      .sximm8    (sximm8),
      .sximm5    (sximm5),
      .PC        (PC),
      .halted    (halted),
      .fault     (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts every cycle in which the start pulse is high.
   always @(negedge clk) begin
      if (s === 1'b1) s_cnt++;
   end

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Wait (bounded) for a read request, check its address, answer it one
   // cycle later.  Returns in ISSUE, just after IR has been loaded.
   task automatic serve_fetch(input string tag, input logic [8:0] exp_addr,
                              input logic [15:0] data);
      int n;
      n = 0;
      while (mem_rd !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check_val({tag, "_rd"}, {31'd0, mem_rd}, 32'd1);
      check_val({tag, "_addr"}, {23'd0, mem_addr}, {23'd0, exp_addr});
      mem_rdata = data;
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
   endtask

   initial begin
      reset     = 1'b0;
      w         = 1'b1;
      pc_load   = 1'b0;
      pc_in     = 9'd0;
      mem_ready = 1'b0;
      mem_rdata = 16'd0;

      #3;
      check_val("rst_pc", {23'd0, PC}, 32'd0);
      check_val("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
      check_val("rst_s", {31'd0, s}, 32'd0);
      check_val("rst_halted", {31'd0, halted}, 32'd0);
      check_val("rst_fault", {31'd0, fault}, 32'd0);
      check_val("rst_decode", {opcode, op, rn, rd, shift, rm}, 32'd0);
      check_val("rst_sximm", {sximm8, sximm5}, 32'd0);

      // Release between edges; the first rising edge launches the read.
      @(negedge clk);
      #1;
      reset = 1'b1;
      tick();
      check_val("first_fetch_rd", {31'd0, mem_rd}, 32'd1);

      // MOV R1,#5
      serve_fetch("mov", 9'h000, 16'hD105);
      check_val("mov_opcode", {29'd0, opcode}, 32'd6);
      check_val("mov_op", {30'd0, op}, 32'd2);
      check_val("mov_rn", {29'd0, rn}, 32'd1);
      check_val("mov_sximm8", {16'd0, sximm8}, 32'h0005);
      check_val("mov_sximm5", {16'd0, sximm5}, 32'h0005);
      check_val("mov_pc", {23'd0, PC}, 32'd1);
      check_val("mov_rd_low", {31'd0, mem_rd}, 32'd0);
      tick();
      check_val("mov_s", {31'd0, s}, 32'd1);

      // Branch while executing
      w       = 1'b0;
      pc_load = 1'b1;
      pc_in   = 9'h040;
      tick();
      check_val("br_pc", {23'd0, PC}, 32'h040);
      pc_load = 1'b0;
      w       = 1'b1;
      tick();
      check_val("mov_s_count", s_cnt, 32'd1);
      serve_fetch("br", 9'h040, 16'h6A9F);
      w = 1'b0;
      check_val("neg_decode", {16'd0, opcode, op, rn, rd, shift, rm},
                {16'd0, 3'b011, 2'b01, 3'b010, 3'b100, 2'b11, 3'b111});
      check_val("neg_sximm8", {16'd0, sximm8}, 32'hFF9F);
      check_val("neg_sximm5", {16'd0, sximm5}, 32'hFFFF);
      check_val("neg_pc", {23'd0, PC}, 32'h041);

      // Controller stall, with stray mem_ready that must be ignored
      base      = s_cnt;
      mem_ready = 1'b1;
      mem_rdata = 16'hFFFF;
      repeat (10) tick();
      mem_ready = 1'b0;
      check_val("stall_no_s", s_cnt, base);
      check_val("stray_ready_ir", {29'd0, opcode}, 32'd3);
      check_val("stray_ready_pc", {23'd0, PC}, 32'h041);
      w = 1'b1;
      tick();
      check_val("stall_s_hi", {31'd0, s}, 32'd1);
      tick();
      check_val("stall_s_lo", {31'd0, s}, 32'd0);
      check_val("stall_s_count", s_cnt, base + 1);

      // Branch to 511 and check the increment wraps
      w       = 1'b0;
      pc_load = 1'b1;
      pc_in   = 9'h1FF;
      tick();
      pc_load = 1'b0;
      w       = 1'b1;
      serve_fetch("wrap", 9'h1FF, 16'h2000);
      check_val("wrap_pc", {23'd0, PC}, 32'd0);
      tick();
      w = 1'b0;
      tick();
      w = 1'b1;

      // Halt
      serve_fetch("halt", 9'h000, 16'hE000);
      base = s_cnt;
      repeat (20) tick();
      check_val("halt_flag", {31'd0, halted}, 32'd1);
      check_val("halt_pc", {23'd0, PC}, 32'd1);
      check_val("halt_opcode", {29'd0, opcode}, 32'd7);
      check_val("halt_no_s", s_cnt, base);
      check_val("halt_no_rd", {31'd0, mem_rd}, 32'd0);

      // Reset clears halt; then reset in the middle of a read
      reset = 1'b0;
      #1;
      check_val("rst2_halted", {31'd0, halted}, 32'd0);
      tick();
      reset = 1'b1;
      serve_fetch("rst2", 9'h000, 16'hD105);
      tick();
      w = 1'b0;
      tick();
      w = 1'b1;
      begin
         int n;
         n = 0;
         while (mem_rd !== 1'b1 && n < 20) begin
            tick();
            n++;
         end
      end
      check_val("midrd_addr", {23'd0, mem_addr}, 32'd1);
      base = s_cnt;
      #2;
      reset = 1'b0;
      #1;
      check_val("midrd_pc", {23'd0, PC}, 32'd0);
      check_val("midrd_rd", {31'd0, mem_rd}, 32'd0);
      check_val("midrd_s", {31'd0, s}, 32'd0);
      check_val("midrd_ir", {29'd0, opcode}, 32'd0);
      tick();
      tick();
      check_val("midrd_no_s", s_cnt, base);

      // Read never answered
      reset = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         tick();
         if (k == 15) check_val("tmo_fault_c15", {31'd0, fault}, 32'd0);
         if (k == 16) begin
            check_val("tmo_fault_c16", {31'd0, fault}, {31'd0, TMO});
            check_val("tmo_rd_c16", {31'd0, mem_rd}, {31'd0, ~TMO});
         end
      end
      repeat (30) tick();
      check_val("tmo_fault_late", {31'd0, fault}, {31'd0, TMO});
      check_val("tmo_rd_late", {31'd0, mem_rd}, {31'd0, ~TMO});
      check_val("tmo_no_s", s_cnt, base);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
